// File: rtl/crc_arb_ctrl.sv
// Round-robin arbiter and byte sequencer for a shared CRC8 engine.
// Two requesters stream 32-bit words with a byte mask. The owner keeps the
// engine for a whole packet. Bytes are folded into the CRC one per cycle,
// and the result is returned with a one-cycle valid pulse to the owner.
module crc_arb_ctrl #(
    parameter logic [7:0] CRC_POLY   = 8'h07,
    parameter logic [7:0] CRC_INIT   = 8'h00,
    parameter logic [7:0] CRC_XOROUT = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_i,
    input  logic [31:0] data0_i,
    input  logic [31:0] data1_i,
    input  logic [3:0]  we0_i,
    input  logic [3:0]  we1_i,
    input  logic        last0_i,
    input  logic        last1_i,
    output logic [1:0]  grant_o,
    output logic [1:0]  ready_o,
    output logic [7:0]  crc_o,
    output logic [1:0]  crc_valid_o,
    output logic        err_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_r, state_s;
    logic        owner_r;      // index of the requester holding the engine
    logic        rr_r;         // index of the last requester served
    logic [31:0] word_r;
    logic [2:0]  nbytes_r;
    logic [1:0]  idx_r;
    logic        last_r;
    logic [7:0]  crc_r;
    logic [1:0]  grant_r;
    logic [1:0]  crc_valid_r;
    logic [7:0]  crc_out_r;
    logic        err_r;
    logic        busy_r;

    logic        win_s;
    logic        owner_req_s;
    logic [31:0] owner_data_s;
    logic [3:0]  owner_we_s;
    logic        owner_last_s;
    logic        accept_s;
    logic        legal_s;
    logic [2:0]  mask_n_s;
    logic [1:0]  ready_s;
    logic [7:0]  byte_s;
    logic [7:0]  crc_next_s;
    logic        last_byte_s;

    // One CRC8 update: fold a byte in and run eight MSB-first division steps.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc_in, input logic [7:0] data);
        logic [7:0] c;
        c = crc_in ^ data;
        for (int i = 0; i < 8; i++) begin
            if (c[7]) begin
                c = {c[6:0], 1'b0} ^ CRC_POLY;
            end else begin
                c = {c[6:0], 1'b0};
            end
        end
        return c;
    endfunction

    // Byte count for a contiguous low-aligned mask; zero marks an illegal mask.
    function automatic logic [2:0] mask_bytes(input logic [3:0] m);
        case (m)
            4'b0001: return 3'd1;
            4'b0011: return 3'd2;
            4'b0111: return 3'd3;
            4'b1111: return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [1:0] onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

    // Arbitration winner and owner-side input muxing.
    always_comb begin
        win_s = 1'b0;
        if (req_i == 2'b11) begin
            win_s = ~rr_r;
        end else if (req_i[1]) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
        if (owner_r) begin
            owner_req_s  = req_i[1];
            owner_data_s = data1_i;
            owner_we_s   = we1_i;
            owner_last_s = last1_i;
        end else begin
            owner_req_s  = req_i[0];
            owner_data_s = data0_i;
            owner_we_s   = we0_i;
            owner_last_s = last0_i;
        end
    end

    // Word acceptance, ready strobe and current-byte selection.
    always_comb begin
        accept_s = (state_r == FETCH) && owner_req_s && (owner_we_s != 4'b0000);
        mask_n_s = mask_bytes(owner_we_s);
        legal_s  = (mask_n_s != 3'd0);
        ready_s  = 2'b00;
        if (accept_s) begin
            ready_s = onehot(owner_r);
        end else begin
            ready_s = 2'b00;
        end
        case (idx_r)
            2'd0:    byte_s = word_r[7:0];
            2'd1:    byte_s = word_r[15:8];
            2'd2:    byte_s = word_r[23:16];
            2'd3:    byte_s = word_r[31:24];
            default: byte_s = word_r[7:0];
        endcase
        crc_next_s  = crc8_step(crc_r, byte_s);
        last_byte_s = ({1'b0, idx_r} == (nbytes_r - 3'd1));
    end

    // Next-state logic for the packet sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_i != 2'b00) begin
                    state_s = FETCH;
                end else begin
                    state_s = IDLE;
                end
            end
            FETCH: begin
                if (accept_s && legal_s) begin
                    state_s = SHIFT;
                end else begin
                    state_s = FETCH;
                end
            end
            SHIFT: begin
                if (last_byte_s) begin
                    state_s = last_r ? DONE : FETCH;
                end else begin
                    state_s = SHIFT;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Owner capture on grant and round-robin pointer update at packet end.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_r <= 1'b0;
            rr_r    <= 1'b1;
        end else begin
            if (state_r == IDLE && state_s == FETCH) begin
                owner_r <= win_s;
            end
            if (state_r == DONE) begin
                rr_r <= owner_r;
            end
        end
    end

    // Word capture and byte index; CRC restarts on grant and advances per byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_r   <= 32'd0;
            nbytes_r <= 3'd0;
            last_r   <= 1'b0;
            idx_r    <= 2'd0;
            crc_r    <= CRC_INIT;
        end else begin
            if (accept_s && legal_s) begin
                word_r   <= owner_data_s;
                nbytes_r <= mask_n_s;
                last_r   <= owner_last_s;
                idx_r    <= 2'd0;
            end else if (state_r == SHIFT) begin
                idx_r <= idx_r + 2'd1;
            end
            if (state_r == IDLE && state_s == FETCH) begin
                crc_r <= CRC_INIT;
            end else if (state_r == SHIFT) begin
                crc_r <= crc_next_s;
            end
        end
    end

    // Registered outputs aligned with the state they describe; err_o is seen
    // the cycle after the illegal word was consumed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_r     <= 2'b00;
            crc_valid_r <= 2'b00;
            crc_out_r   <= 8'h00;
            err_r       <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            if (state_s == IDLE) begin
                grant_r <= 2'b00;
            end else if (state_r == IDLE) begin
                grant_r <= onehot(win_s);
            end
            if (state_s == DONE) begin
                crc_valid_r <= onehot(owner_r);
                crc_out_r   <= crc_next_s ^ CRC_XOROUT;
            end else begin
                crc_valid_r <= 2'b00;
            end
            err_r  <= accept_s && !legal_s;
            busy_r <= (state_s != IDLE);
        end
    end

    assign grant_o     = grant_r;
    assign ready_o     = ready_s;
    assign crc_o       = crc_out_r;
    assign crc_valid_o = crc_valid_r;
    assign err_o       = err_r;
    assign busy_o      = busy_r;

endmodule

// File: tb/tb_crc_arb_ctrl.sv
// Scoreboard bench for crc_arb_ctrl: requester drivers push expected CRCs
// from a polynomial-division reference; a negedge monitor pops and compares.
module tb_crc_arb_ctrl;

    localparam logic [7:0] POLY   = 8'h07;
    localparam logic [7:0] INIT   = 8'h00;
    localparam logic [7:0] XOROUT = 8'h00;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [31:0] data0 = 32'd0, data1 = 32'd0;
    logic [3:0]  we0 = 4'd0, we1 = 4'd0;
    logic        last0 = 1'b0, last1 = 1'b0;
    wire  [1:0]  req_i = {req1, req0};
    logic [1:0]  grant_o, ready_o, crc_valid_o;
    logic [7:0]  crc_o;
    logic        err_o, busy_o;

    crc_arb_ctrl #(.CRC_POLY(POLY), .CRC_INIT(INIT), .CRC_XOROUT(XOROUT)) dut (
        .clk(clk), .reset(reset), .req_i(req_i),
        .data0_i(data0), .data1_i(data1), .we0_i(we0), .we1_i(we1),
        .last0_i(last0), .last1_i(last1),
        .grant_o(grant_o), .ready_o(ready_o), .crc_o(crc_o),
        .crc_valid_o(crc_valid_o), .err_o(err_o), .busy_o(busy_o)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int err_cnt = 0;
    int done_cyc [2];
    int acc_log [2][8];
    logic [31:0] pk_data [2][8];
    logic [3:0]  pk_we [2][8];
    logic [7:0]  exp_q0 [$];
    logic [7:0]  exp_q1 [$];
    logic        glog [$];
    string       dq_name [$];
    logic [31:0] dq_act [$];
    logic [31:0] dq_exp [$];

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    // Queue a directed comparison; the monitor performs it.
    task automatic rec(input string n, input logic [31:0] a, input logic [31:0] e);
        dq_name.push_back(n);
        dq_act.push_back(a);
        dq_exp.push_back(e);
    endtask

    // Reference CRC: long division of message*x^8 by x^8+POLY, bits MSB-first.
    function automatic logic [7:0] model_crc(input int r, input int nw);
        logic [7:0] bq [$];
        logic [8:0] rem;
        logic [7:0] bb;
        logic [3:0] m;
        for (int k = 0; k < nw; k++) begin
            m = pk_we[r][k];
            if (m != 4'd0 && (m & (m + 4'd1)) == 4'd0) begin
                for (int b = 0; b < 4; b++)
                    if (m[b]) bq.push_back(pk_data[r][k][8*b +: 8]);
            end
        end
        rem = 9'd0;
        for (int i = 0; i < bq.size() + 1; i++) begin
            if (i < bq.size()) bb = bq[i] ^ ((i == 0) ? INIT : 8'h00);
            else bb = 8'h00;
            for (int j = 7; j >= 0; j--) begin
                rem = {rem[7:0], bb[j]};
                if (rem[8]) rem = rem ^ {1'b1, POLY};
            end
        end
        return rem[7:0] ^ XOROUT;
    endfunction

    task automatic exp_push(input int r, input logic [7:0] v);
        if (r == 0) exp_q0.push_back(v); else exp_q1.push_back(v);
    endtask

    task automatic drive(input int r, input logic [31:0] d, input logic [3:0] w,
                         input logic l, input logic q);
        if (r == 0) begin req0 = q; data0 = d; we0 = w; last0 = l; end
        else begin req1 = q; data1 = d; we1 = w; last1 = l; end
    endtask

    // Stream pk_data[r][0..nw-1]; called just after a rising edge.
    task automatic send_packet(input int r, input int nw, input bit mark_last,
                               input bit hold_req, input bit stall_en);
        int k;
        int guard;
        bit stall;
        k = 0;
        guard = 0;
        while (k < nw && guard < 1000) begin
            stall = stall_en && ($urandom_range(0, 3) == 0);
            if (stall) drive(r, $urandom, 4'b0000, 1'b0, $urandom_range(0, 1) == 1);
            else drive(r, pk_data[r][k], pk_we[r][k], mark_last && (k == nw - 1), 1'b1);
            @(negedge clk);
            if (!stall && ready_o[r]) begin
                acc_log[r][k] = cyc;
                k++;
            end
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 1000) rec("send_timeout", 32'd1, 32'd0);
        drive(r, 32'd0, 4'b0000, 1'b0, hold_req);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy_o && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) rec("idle_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic rr_stream(input int r, input int npk, input bit hold);
        for (int p = 0; p < npk; p++) begin
            pk_data[r][0] = $urandom;
            pk_we[r][0] = 4'b0001;
            exp_push(r, model_crc(r, 1));
            send_packet(r, 1, 1'b1, hold, 1'b0);
        end
        drive(r, 32'd0, 4'b0000, 1'b0, 1'b0);
    endtask

    task automatic rand_stream(input int r);
        int nw;
        logic [3:0] m;
        for (int p = 0; p < 6; p++) begin
            nw = $urandom_range(1, 4);
            for (int k = 0; k < nw; k++) begin
                pk_data[r][k] = $urandom;
                if (k < nw - 1 && $urandom_range(0, 4) == 0) begin
                    do m = 4'($urandom_range(1, 15)); while ((m & (m + 4'd1)) == 4'd0);
                end else begin
                    case ($urandom_range(0, 3))
                        0: m = 4'b0001;
                        1: m = 4'b0011;
                        2: m = 4'b0111;
                        default: m = 4'b1111;
                    endcase
                end
                pk_we[r][k] = m;
            end
            exp_push(r, model_crc(r, nw));
            send_packet(r, nw, 1'b1, 1'b0, 1'b1);
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
    endtask

    task automatic load_123456789(input int r);
        pk_data[r][0] = 32'h34333231; pk_we[r][0] = 4'b1111;
        pk_data[r][1] = 32'h38373635; pk_we[r][1] = 4'b1111;
        pk_data[r][2] = 32'h00000039; pk_we[r][2] = 4'b0001;
    endtask

    // Monitor: invariants, scoreboard pops on result pulses, directed records.
    initial begin
        logic [1:0] prev_grant;
        logic [7:0] e;
        prev_grant = 2'b00;
        forever begin
            @(negedge clk);
            checks++;
            if ($countones(grant_o) > 1 || $countones(ready_o) > 1 ||
                $countones(crc_valid_o) > 1 || (ready_o & ~grant_o) != 2'b00 ||
                busy_o != (grant_o != 2'b00)) begin
                errors++;
                $display("FAIL invariant grant=%b ready=%b valid=%b busy=%b", grant_o, ready_o, crc_valid_o, busy_o);
            end
            if (crc_valid_o != 2'b00) begin
                checks++;
                if (crc_valid_o != grant_o) begin
                    errors++;
                    $display("FAIL valid_owner valid=%b required grant=%b", crc_valid_o, grant_o);
                end
                if (crc_valid_o[0] ? exp_q0.size() == 0 : exp_q1.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_crc valid=%b crc=%h required no result", crc_valid_o, crc_o);
                end else begin
                    e = crc_valid_o[0] ? exp_q0.pop_front() : exp_q1.pop_front();
                    if (crc_o != e) begin
                        errors++;
                        $display("FAIL crc_req%0d actual=%h required=%h", crc_valid_o[1], crc_o, e);
                    end
                end
                done_cyc[crc_valid_o[1]] = cyc;
            end
            if (err_o) err_cnt++;
            if (grant_o != 2'b00 && prev_grant == 2'b00) glog.push_back(grant_o[1]);
            prev_grant = grant_o;
            while (dq_name.size() > 0) begin
                string n;
                logic [31:0] a, x;
                n = dq_name.pop_front();
                a = dq_act.pop_front();
                x = dq_exp.pop_front();
                checks++;
                if (a !== x) begin
                    errors++;
                    $display("FAIL %s actual=%0h required=%0h", n, a, x);
                end
            end
        end
    end

    initial begin
        int base;
        int eb;
        logic [7:0] gv;
        // Reset state, with a request pending that must not raise ready.
        drive(0, 32'hFFFFFFFF, 4'b1111, 1'b1, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rec("reset_grant", {30'd0, grant_o}, 32'd0);
        rec("reset_ready", {30'd0, ready_o}, 32'd0);
        rec("reset_valid", {30'd0, crc_valid_o}, 32'd0);
        rec("reset_crc_err_busy", {22'd0, crc_o, err_o, busy_o}, 32'd0);
        drive(0, 32'd0, 4'b0000, 1'b0, 1'b0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Check string "123456789" and its latency.
        load_123456789(0);
        exp_push(0, 8'hF4);
        send_packet(0, 3, 1'b1, 1'b0, 1'b0);
        wait_idle();
        rec("done_latency", done_cyc[0] - acc_log[0][0], 32'd12);
        rec("crc_hold", {24'd0, crc_o}, 32'h000000F4);

        // Single bytes.
        pk_data[1][0] = 32'h000000FF; pk_we[1][0] = 4'b0001;
        exp_push(1, 8'hF3);
        send_packet(1, 1, 1'b1, 1'b0, 1'b0);
        wait_idle();
        pk_data[0][0] = 32'hABCDEF00; pk_we[0][0] = 4'b0001;
        exp_push(0, 8'h00);
        send_packet(0, 1, 1'b1, 1'b0, 1'b0);
        wait_idle();

        // Illegal mask dropped, then the check string.
        eb = err_cnt;
        pk_data[0][0] = 32'h11111111; pk_we[0][0] = 4'b0101;
        pk_data[0][1] = 32'h34333231; pk_we[0][1] = 4'b1111;
        pk_data[0][2] = 32'h38373635; pk_we[0][2] = 4'b1111;
        pk_data[0][3] = 32'h00000039; pk_we[0][3] = 4'b0001;
        exp_push(0, 8'hF4);
        send_packet(0, 4, 1'b1, 1'b0, 1'b0);
        wait_idle();
        rec("err_pulses", err_cnt - eb, 32'd1);
        rec("illegal_no_shift", acc_log[0][1] - acc_log[0][0], 32'd1);

        // Asynchronous reset during SHIFT of the second word.
        load_123456789(0);
        send_packet(0, 2, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        rec("busy_before_reset", {31'd0, busy_o}, 32'd1);
        reset = 1'b1;
        #1;
        rec("midreset_outs", {16'd0, grant_o, ready_o, crc_valid_o, err_o, crc_o, busy_o}, 32'd0);
        drive(0, 32'd0, 4'b0000, 1'b0, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Round-robin with both requests held from reset release.
        base = glog.size();
        fork
            rr_stream(0, 4, 1'b1);
            rr_stream(1, 4, 1'b1);
        join
        wait_idle();
        gv = 8'd0;
        for (int i = 0; i < 8; i++) if (base + i < glog.size()) gv[i] = glog[base + i];
        rec("rr_order", {24'd0, gv}, 32'h000000AA);
        rec("rr_count", glog.size() - base, 32'd8);

        // Fresh packet after the reset gives the right CRC.
        load_123456789(1);
        exp_push(1, 8'hF4);
        send_packet(1, 3, 1'b1, 1'b0, 1'b0);
        wait_idle();

        // Sole requester is always granted.
        base = glog.size();
        rr_stream(0, 3, 1'b0);
        wait_idle();
        rec("sole_count", glog.size() - base, 32'd3);
        gv = 8'd0;
        for (int i = 0; i < 3; i++) if (base + i < glog.size()) gv[i] = glog[base + i];
        rec("sole_order", {24'd0, gv}, 32'd0);

        // Lock: requester 1 asks mid-packet of requester 0.
        base = glog.size();
        load_123456789(0);
        pk_data[1][0] = 32'h0000005A; pk_we[1][0] = 4'b0001;
        exp_push(0, 8'hF4);
        exp_push(1, model_crc(1, 1));
        fork
            send_packet(0, 3, 1'b1, 1'b0, 1'b0);
            begin
                repeat (3) @(posedge clk);
                #1;
                send_packet(1, 1, 1'b1, 1'b0, 1'b0);
            end
        join
        wait_idle();
        gv = 8'd0;
        for (int i = 0; i < 2; i++) if (base + i < glog.size()) gv[i] = glog[base + i];
        rec("lock_order", {24'd0, gv}, 32'h00000002);

        // Randomized traffic from both requesters.
        fork
            rand_stream(0);
            rand_stream(1);
        join
        wait_idle();

        rec("q0_drained", exp_q0.size(), 32'd0);
        rec("q1_drained", exp_q1.size(), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/crc_arb_ctrl.md
Name: crc_arb_ctrl

Overview:
Round-robin arbiter and sequencer for the shared byte-serial CRC8 engine in the packet-processing path. It serves two requesters, for example the parser and the builder. Each requester streams 32-bit words with a byte-write mask, using the same word/byte layout as the CRC FIFO (byte 0 = data[7:0], processed first). The block locks the engine to one requester for a whole packet, serialises bytes one per cycle and returns the final CRC8 with a one-cycle valid pulse to the owning requester.

Parameters:
CRC_POLY, 8'h07, CRC8 generator polynomial (MSB-first, no reflection)
CRC_INIT, 8'h00, CRC register value at packet start
CRC_XOROUT, 8'h00, value XORed into the final CRC

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
req_i  in  2  requester r wants or holds the engine
data0_i  in  32  requester 0 word
data1_i  in  32  requester 1 word
we0_i  in  4  requester 0 byte mask (legal: 0001, 0011, 0111, 1111)
we1_i  in  4  requester 1 byte mask
last0_i  in  1  requester 0 word is last of packet
last1_i  in  1  requester 1 word is last of packet
grant_o  out  2  one-hot owner of engine
ready_o  out  2  word accept strobe per requester
crc_o  out  8  final CRC, meaningful while any crc_valid_o bit is set
crc_valid_o  out  2  one-cycle result pulse to owner
err_o  out  1  one-cycle pulse on illegal byte mask
busy_o  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock (clk). reset is asynchronous and active-high.
- Reset values: state=IDLE, grant_o=0, ready_o=0, crc_valid_o=0, err_o=0, crc_o=0, busy_o=0, crc register=CRC_INIT, rr pointer=1 (so requester 0 wins the first tie).
- States: IDLE, FETCH, SHIFT, DONE.
- IDLE:
  - If req_i!=0, pick the winner round-robin: the requester after the last served one wins a tie; a sole requester wins outright.
  - Next cycle enter FETCH with grant_o set; crc register loaded with CRC_INIT.
- FETCH:
  - ready_o[g] = req_i[g] && (we_g!=0); it is combinational, and acceptance happens on that edge.
  - Legal mask: capture word, byte count N = 1..4, last flag; go to SHIFT.
  - Illegal nonzero mask (e.g. 0101, 1000): pulse err_o, drop the word, ready_o still pulses (word consumed), stay in FETCH.
  - req drop or we=0: wait in FETCH; grant is held until packet end.
- SHIFT:
  - One byte per cycle, byte 0 first.
  - crc = crc8_step(crc ^ byte) over 8 bit iterations: if msb, (crc<<1)^CRC_POLY, else crc<<1.
  - After byte N-1: go to DONE if last, else FETCH.
  - A 4-byte word therefore costs 5 cycles (1 FETCH + 4 SHIFT).
- DONE:
  - crc_o = crc ^ CRC_XOROUT; crc_valid_o[g] = 1 for one cycle.
  - Update rr pointer to g; clear grant; go to IDLE.
  - The next arbitration decision is made in IDLE, so there is at least one idle cycle between packets.
- Non-owner signals: req_i or we of the non-owner are ignored while a packet is in progress; its ready_o stays 0.
- Mid-packet reset: asynchronous clear to reset values; the partial CRC is discarded and no crc_valid_o is emitted.
- Invariants: grant_o, ready_o and crc_valid_o are always one-hot or zero. ready_o only when state==FETCH. crc_o holds its value after DONE until the next DONE.

Test Plan:
- "123456789" via req 0: words 0x34333231/1111, 0x38373635/1111, 0x00000039/0001 with last -> crc_valid_o=01, crc_o=0xF4. With FETCH at cycle T+0 and the first-word accept at T, DONE falls at T+12.
- Single byte 0xFF via req 1, we 0001, last -> crc_o=0xF3, crc_valid_o=10. Single byte 0x00 -> crc_o=0x00.
- Round-robin: req_i=11 held continuously out of reset, each packet one byte -> grant order 0,1,0,1. A single requester with req_i=01 repeatedly is always granted.
- Lock: req 1 asserts mid-packet of req 0 -> grant_o stays 01 until DONE; req 1 is served next with ready_o[1] never high during req 0's packet.
- Illegal mask 0101 in FETCH -> err_o pulse, no SHIFT, state stays FETCH. A subsequent legal "123456789" stream gives 0xF4.
- Async reset asserted during SHIFT of the second word -> all outputs 0 immediately, busy_o=0, no crc_valid_o. A fresh packet after release gives the correct CRC.
